// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the five-stage pipeline and its stall/flush controller.
// The stall_cycles member exists only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        memreq;
    logic        flushreq;
    logic [4:0]  stall;
    logic        flush;
    logic        busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cycles;
`endif

    modport master (
        input  stallreq_id,
        input  memreq,
        input  flushreq,
        output stall,
        output flush,
`ifdef PIPE_CTRL_PERF_EN
        output stall_cycles,
`endif
        output busy
    );

    modport slave (
        output stallreq_id,
        output memreq,
        output flushreq,
        input  stall,
        input  flush,
`ifdef PIPE_CTRL_PERF_EN
        input  stall_cycles,
`endif
        input  busy
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 16-bit five-stage pipeline: load-use bubbles, multi-cycle
// shared-bus accesses from MEM and control-flow flushes. Optional PIPE_CTRL_PERF_EN adds a stall counter.
//
// state | meaning
// RUN   | normal flow; a MEM bus request starts an access, else flush / load-use handled
// WAIT  | bus access in progress, pc..ex_mem held, all requests deferred or ignored
// DONE  | MEM instruction advances; memreq ignored, deferred flush issued
module pipe_ctrl #(
    parameter int MEM_WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT_CYCLES - 1);
    localparam logic [4:0] STALL_MEM = 5'b01111;
    localparam logic [4:0] STALL_LU  = 5'b00011;

    state_t     state;
    logic [3:0] cnt;
    logic       flush_pend;

    logic       in_wait;
    logic       mem_start;
    logic       flush_any;

    always_comb begin
        in_wait   = (state == ST_WAIT);
        mem_start = (state == ST_RUN) & bus.memreq;
        flush_any = bus.flushreq | flush_pend;
        bus.stall = '0;
        bus.flush = 1'b0;
        bus.busy  = 1'b0;
        if (!rst) begin
            bus.busy = in_wait;
            if (in_wait || mem_start) begin
                bus.stall = STALL_MEM;
            end else if (flush_any) begin
                // flushed ID instruction is killed, so its load-use request is moot
                bus.flush = 1'b1;
            end else if (bus.stallreq_id) begin
                bus.stall = STALL_LU;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.memreq) begin
                        cnt        <= WAIT_LOAD;
                        flush_pend <= bus.flushreq;
                        state      <= (WAIT_LOAD == 4'd0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt        <= cnt - 4'd1;
                    flush_pend <= flush_pend | bus.flushreq;
                    if (cnt == 4'd1) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state      <= ST_RUN;
                    flush_pend <= 1'b0;
                end
                default: begin
                    state      <= ST_RUN;
                    flush_pend <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
        end else if ((bus.stall != 5'b00000) && (perf_cnt != 16'hFFFF)) begin
            perf_cnt <= perf_cnt + 16'd1;
        end
    end

    assign bus.stall_cycles = perf_cnt;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: three instances (MEM_WAIT_CYCLES 2, 1, 4) share directed and random
// stimulus and are compared every cycle against an access-level model.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stallreq_id = 1'b1;
    logic memreq = 1'b1;
    logic flushreq = 1'b1;

    always #5 clk = ~clk;

    pipe_ctrl_if if_a ();
    pipe_ctrl_if if_b ();
    pipe_ctrl_if if_c ();

    assign if_a.stallreq_id = stallreq_id;
    assign if_a.memreq      = memreq;
    assign if_a.flushreq    = flushreq;
    assign if_b.stallreq_id = stallreq_id;
    assign if_b.memreq      = memreq;
    assign if_b.flushreq    = flushreq;
    assign if_c.stallreq_id = stallreq_id;
    assign if_c.memreq      = memreq;
    assign if_c.flushreq    = flushreq;

    pipe_ctrl #(.MEM_WAIT_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    pipe_ctrl #(.MEM_WAIT_CYCLES(1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    pipe_ctrl #(.MEM_WAIT_CYCLES(4)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    logic [4:0]  a_stall [3];
    logic        a_flush [3];
    logic        a_busy  [3];
    logic [15:0] a_perf  [3];

    assign a_stall[0] = if_a.stall;
    assign a_stall[1] = if_b.stall;
    assign a_stall[2] = if_c.stall;
    assign a_flush[0] = if_a.flush;
    assign a_flush[1] = if_b.flush;
    assign a_flush[2] = if_c.flush;
    assign a_busy[0]  = if_a.busy;
    assign a_busy[1]  = if_b.busy;
    assign a_busy[2]  = if_c.busy;
`ifdef PIPE_CTRL_PERF_EN
    assign a_perf[0] = if_a.stall_cycles;
    assign a_perf[1] = if_b.stall_cycles;
    assign a_perf[2] = if_c.stall_cycles;
`else
    assign a_perf[0] = '0;
    assign a_perf[1] = '0;
    assign a_perf[2] = '0;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model: an access is "cycles still to hold after the entry cycle" plus a one-cycle
    // cool-down in which memreq is ignored and any deferred flush goes out.
    int       mwc     [3] = '{2, 1, 4};
    int       m_left  [3] = '{0, 0, 0};
    bit       m_cool  [3] = '{0, 0, 0};
    bit       m_pend  [3] = '{0, 0, 0};
    int       m_perf  [3] = '{0, 0, 0};
    logic [4:0] e_stall [3];
    logic       e_flush [3];
    logic       e_busy  [3];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            e_stall[k] = 5'b00000;
            e_flush[k] = 1'b0;
            e_busy[k]  = 1'b0;
            if (!rst) begin
                if (m_left[k] > 0) begin
                    e_stall[k] = 5'b01111;
                    e_busy[k]  = 1'b1;
                end else if (memreq && !m_cool[k]) begin
                    e_stall[k] = 5'b01111;
                end else if (flushreq || m_pend[k]) begin
                    e_flush[k] = 1'b1;
                end else if (stallreq_id) begin
                    e_stall[k] = 5'b00011;
                end
            end
            check($sformatf("stall[%0d]", k), {11'd0, a_stall[k]}, {11'd0, e_stall[k]});
            check($sformatf("flush[%0d]", k), {15'd0, a_flush[k]}, {15'd0, e_flush[k]});
            check($sformatf("busy[%0d]", k),  {15'd0, a_busy[k]},  {15'd0, e_busy[k]});
`ifdef PIPE_CTRL_PERF_EN
            check($sformatf("stall_cycles[%0d]", k), a_perf[k], 16'(m_perf[k]));
`endif
            if (rst) begin
                m_left[k] = 0;
                m_cool[k] = 1'b0;
                m_pend[k] = 1'b0;
                m_perf[k] = 0;
            end else begin
                if (e_stall[k] != 5'b00000 && m_perf[k] < 65535) m_perf[k]++;
                if (m_left[k] > 0) begin
                    m_pend[k] = m_pend[k] | flushreq;
                    m_left[k]--;
                    m_cool[k] = (m_left[k] == 0);
                end else if (memreq && !m_cool[k]) begin
                    m_pend[k] = flushreq;
                    m_left[k] = mwc[k] - 1;
                    m_cool[k] = (m_left[k] == 0);
                end else begin
                    m_pend[k] = 1'b0;
                    m_cool[k] = 1'b0;
                end
            end
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit s, input bit m, input bit f);
        @(posedge clk);
        #1;
        rst = r;
        stallreq_id = s;
        memreq = m;
        flushreq = f;
        sample();
    endtask

    // literal pins both the DUT and the model
    task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] mdl,
                       input logic [15:0] exp);
        check({nm, " dut"}, act, exp);
        check({nm, " model"}, mdl, exp);
    endtask

    initial begin
        sample();
        lit("rst1 stall", {11'd0, a_stall[0]}, {11'd0, e_stall[0]}, 16'h0000);
        lit("rst1 flush", {15'd0, a_flush[0]}, {15'd0, e_flush[0]}, 16'h0000);
        lit("rst1 busy",  {15'd0, a_busy[0]},  {15'd0, e_busy[0]},  16'h0000);
        drive(1, 1, 1, 1);
        lit("rst2 stall", {11'd0, a_stall[0]}, {11'd0, e_stall[0]}, 16'h0000);
        drive(0, 0, 0, 0);
        lit("run idle stall", {11'd0, a_stall[0]}, {11'd0, e_stall[0]}, 16'h0000);

        drive(0, 1, 0, 0);
        lit("loaduse stall", {11'd0, a_stall[0]}, {11'd0, e_stall[0]}, 16'h0003);
        drive(0, 0, 0, 0);
        lit("loaduse after", {11'd0, a_stall[0]}, {11'd0, e_stall[0]}, 16'h0000);

        drive(0, 0, 1, 0);
        lit("c stall",      {11'd0, a_stall[0]}, {11'd0, e_stall[0]}, 16'h000F);
        lit("c busy",       {15'd0, a_busy[0]},  {15'd0, e_busy[0]},  16'h0000);
        lit("w1 c stall",   {11'd0, a_stall[1]}, {11'd0, e_stall[1]}, 16'h000F);
        drive(0, 0, 1, 1);
        lit("c+1 stall",    {11'd0, a_stall[0]}, {11'd0, e_stall[0]}, 16'h000F);
        lit("c+1 busy",     {15'd0, a_busy[0]},  {15'd0, e_busy[0]},  16'h0001);
        lit("c+1 flush",    {15'd0, a_flush[0]}, {15'd0, e_flush[0]}, 16'h0000);
        lit("w1 c+1 stall", {11'd0, a_stall[1]}, {11'd0, e_stall[1]}, 16'h0000);
        lit("w1 c+1 flush", {15'd0, a_flush[1]}, {15'd0, e_flush[1]}, 16'h0001);
        drive(0, 0, 1, 0);
        lit("c+2 stall",    {11'd0, a_stall[0]}, {11'd0, e_stall[0]}, 16'h0000);
        lit("c+2 flush",    {15'd0, a_flush[0]}, {15'd0, e_flush[0]}, 16'h0001);
        lit("w1 c+2 stall", {11'd0, a_stall[1]}, {11'd0, e_stall[1]}, 16'h000F);
`ifdef PIPE_CTRL_PERF_EN
        lit("c+2 stall_cycles", a_perf[0], 16'(m_perf[0]), 16'd3);
`endif
        drive(0, 0, 1, 0);
        lit("c+3 stall",    {11'd0, a_stall[0]}, {11'd0, e_stall[0]}, 16'h000F);
        lit("c+3 flush",    {15'd0, a_flush[0]}, {15'd0, e_flush[0]}, 16'h0000);
        lit("w1 c+3 stall", {11'd0, a_stall[1]}, {11'd0, e_stall[1]}, 16'h0000);

        drive(0, 0, 0, 1);
        lit("wait pend busy", {15'd0, a_busy[0]}, {15'd0, e_busy[0]}, 16'h0001);
        drive(1, 0, 0, 0);
        lit("rst in wait stall", {11'd0, a_stall[0]}, {11'd0, e_stall[0]}, 16'h0000);
        drive(0, 0, 0, 0);
        lit("post rst stall", {11'd0, a_stall[0]}, {11'd0, e_stall[0]}, 16'h0000);
        lit("post rst flush", {15'd0, a_flush[0]}, {15'd0, e_flush[0]}, 16'h0000);
        lit("post rst busy",  {15'd0, a_busy[0]},  {15'd0, e_busy[0]},  16'h0000);
`ifdef PIPE_CTRL_PERF_EN
        lit("post rst stall_cycles", a_perf[0], 16'(m_perf[0]), 16'd0);
`endif
        drive(0, 1, 0, 1);
        lit("flush+lu flush", {15'd0, a_flush[0]}, {15'd0, e_flush[0]}, 16'h0001);
        lit("flush+lu stall", {11'd0, a_stall[0]}, {11'd0, e_stall[0]}, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 35,
                  $urandom_range(0, 99) < 15);
        end
        drive(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
